// File: rtl/dtag_mbist_ctrl.sv
// dtag_mbist_ctrl: March C- memory-BIST controller for the data-cache tag and
// status arrays. It drives one shared address/write/pattern bus to NUM_ARR
// arrays and compares their registered read data with the expected background.
// bist_mode 01 runs March C-, 10 runs a fill-only pass (M0), 00/11 idle.
// Optional macro DTAG_MBIST_DIAG_EN builds capture registers behind
// fail_adr/fail_elem; when it is undefined those ports are tied to 0.
module dtag_mbist_ctrl #(
  parameter int unsigned            ADDR_W  = 9,
  parameter int unsigned            DATA_W  = 19,
  parameter int unsigned            NUM_ARR = 3,
  parameter logic [DATA_W-1:0]      BG_PAT  = '0
) (
  input  logic                      clk,
  input  logic                      bist_reset,
  input  logic [1:0]                bist_mode,
  input  logic [NUM_ARR-1:0]        arr_en,
  input  logic [NUM_ARR*DATA_W-1:0] arr_rdata,
  output logic                      bist_on,
  output logic [ADDR_W-1:0]         bist_adr,
  output logic                      bist_we,
  output logic [DATA_W-1:0]         bist_pattern,
  output logic                      bist_done,
  output logic                      bist_error,
  output logic [NUM_ARR-1:0]        err_vec,
  output logic [ADDR_W-1:0]         fail_adr,
  output logic [2:0]                fail_elem
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_M0    = 4'd1;
  localparam logic [3:0] S_M1    = 4'd2;
  localparam logic [3:0] S_M2    = 4'd3;
  localparam logic [3:0] S_M3    = 4'd4;
  localparam logic [3:0] S_M4    = 4'd5;
  localparam logic [3:0] S_M5    = 4'd6;
  localparam logic [3:0] S_FLUSH = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam logic [ADDR_W-1:0] ADR_MAX = '1;

  logic [3:0]          state;
  logic [ADDR_W-1:0]   adr;
  logic                ph;        // 0: read cycle, 1: write cycle (M1..M4)
  logic                fill;
  logic [NUM_ARR-1:0]  en_q;
  logic [NUM_ARR-1:0]  err_q;
  logic                cmp_valid;
  logic [DATA_W-1:0]   cmp_exp;

  logic                start;
  logic                rw_elem;
  logic                in_march;
  logic                down;
  logic                rd_cyc;
  logic                last;
  logic [ADDR_W-1:0]   end_adr;
  logic [3:0]          nxt_state;
  logic [ADDR_W-1:0]   nxt_adr;
  logic [DATA_W-1:0]   exp_pat;
  logic [NUM_ARR-1:0]  mism;
  logic [NUM_ARR-1:0]  hit;

  // Element decode, bus outputs and end-of-element sequencing.
  always_comb begin
    start    = (state == S_IDLE) && ((bist_mode == 2'b01) || (bist_mode == 2'b10));
    rw_elem  = (state == S_M1) || (state == S_M2) || (state == S_M3) || (state == S_M4);
    in_march = (state == S_M0) || rw_elem || (state == S_M5);
    down     = (state == S_M3) || (state == S_M4) || (state == S_M5);
    rd_cyc   = (rw_elem && !ph) || (state == S_M5);
    end_adr  = down ? '0 : ADR_MAX;
    last     = (adr == end_adr) && (!rw_elem || ph);
    exp_pat  = ((state == S_M2) || (state == S_M4)) ? ~BG_PAT : BG_PAT;

    bist_on      = (state != S_IDLE);
    bist_done    = (state == S_DONE);
    bist_adr     = adr;
    bist_we      = (state == S_M0) || (rw_elem && ph);
    bist_pattern = '0;
    if (in_march)
      bist_pattern = ((state == S_M1) || (state == S_M3)) ? ~BG_PAT : BG_PAT;

    nxt_state = S_IDLE;
    nxt_adr   = '0;
    case (state)
      // Fill passes through FLUSH as well so both modes share one exit path.
      S_M0:    nxt_state = fill ? S_FLUSH : S_M1;
      S_M1:    nxt_state = S_M2;
      S_M2:    begin nxt_state = S_M3; nxt_adr = ADR_MAX; end
      S_M3:    begin nxt_state = S_M4; nxt_adr = ADR_MAX; end
      S_M4:    begin nxt_state = S_M5; nxt_adr = ADR_MAX; end
      S_M5:    nxt_state = S_FLUSH;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Main sequencer: state, address counter and read/write phase.
  always_ff @(posedge clk) begin
    if (bist_reset) begin
      state <= S_IDLE;
      adr   <= '0;
      ph    <= 1'b0;
      fill  <= 1'b0;
      en_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          adr <= '0;
          ph  <= 1'b0;
          if (start) begin
            state <= S_M0;
            fill  <= (bist_mode == 2'b10);
            en_q  <= arr_en;
          end
        end
        S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: begin
          if (rw_elem && !ph) begin
            ph <= 1'b1;
          end else begin
            ph <= 1'b0;
            if (last) begin
              state <= nxt_state;
              adr   <= nxt_adr;
            end else begin
              adr <= down ? adr - 1'b1 : adr + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          state <= S_DONE;
          adr   <= '0;
        end
        S_DONE: begin
          adr <= '0;
          if (bist_mode[1] == bist_mode[0])
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Per-array miscompare against the expected value of the previous read.
  always_comb begin
    mism = '0;
    for (int unsigned i = 0; i < NUM_ARR; i++)
      mism[i] = (arr_rdata[i*DATA_W +: DATA_W] != cmp_exp);
    hit = mism & en_q;
  end

  // Compare pipeline: capture read expectation, then fold mismatches into sticky flags.
  always_ff @(posedge clk) begin
    if (bist_reset || start) begin
      cmp_valid <= 1'b0;
      cmp_exp   <= '0;
      err_q     <= '0;
    end else begin
      cmp_valid <= rd_cyc;
      cmp_exp   <= exp_pat;
      if (cmp_valid)
        err_q <= err_q | hit;
    end
  end

  assign err_vec    = err_q;
  assign bist_error = |err_q;

`ifdef DTAG_MBIST_DIAG_EN
  logic [ADDR_W-1:0] cmp_adr;
  logic [2:0]        cmp_elem;
  logic [ADDR_W-1:0] fail_adr_q;
  logic [2:0]        fail_elem_q;
  logic              failed;

  // Diagnostic capture of the first miscompare of a run.
  always_ff @(posedge clk) begin
    if (bist_reset || start) begin
      cmp_adr     <= '0;
      cmp_elem    <= '0;
      fail_adr_q  <= '0;
      fail_elem_q <= '0;
      failed      <= 1'b0;
    end else begin
      if (rd_cyc) begin
        cmp_adr  <= adr;
        cmp_elem <= state[2:0] - 3'd1;
      end
      if (cmp_valid && (|hit) && !failed) begin
        failed      <= 1'b1;
        fail_adr_q  <= cmp_adr;
        fail_elem_q <= cmp_elem;
      end
    end
  end

  assign fail_adr  = fail_adr_q;
  assign fail_elem = fail_elem_q;
`else
  assign fail_adr  = '0;
  assign fail_elem = '0;
`endif

endmodule

// File: tb/tb_dtag_mbist_ctrl.sv
// Self-checking bench for dtag_mbist_ctrl with ADDR_W=3, three 19-bit arrays
// and a registered-read RAM model with an optional stuck-at-1 fault.
module tb_dtag_mbist_ctrl;

  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned DATA_W  = 19;
  localparam int unsigned NUM_ARR = 3;
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] BG = '0;

  logic                      clk = 1'b0;
  logic                      bist_reset;
  logic [1:0]                bist_mode;
  logic [NUM_ARR-1:0]        arr_en;
  logic [NUM_ARR*DATA_W-1:0] arr_rdata;
  logic                      bist_on;
  logic [ADDR_W-1:0]         bist_adr;
  logic                      bist_we;
  logic [DATA_W-1:0]         bist_pattern;
  logic                      bist_done;
  logic                      bist_error;
  logic [NUM_ARR-1:0]        err_vec;
  logic [ADDR_W-1:0]         fail_adr;
  logic [2:0]                fail_elem;

  dtag_mbist_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NUM_ARR(NUM_ARR),
    .BG_PAT (BG)
  ) dut (
    .clk         (clk),
    .bist_reset  (bist_reset),
    .bist_mode   (bist_mode),
    .arr_en      (arr_en),
    .arr_rdata   (arr_rdata),
    .bist_on     (bist_on),
    .bist_adr    (bist_adr),
    .bist_we     (bist_we),
    .bist_pattern(bist_pattern),
    .bist_done   (bist_done),
    .bist_error  (bist_error),
    .err_vec     (err_vec),
    .fail_adr    (fail_adr),
    .fail_elem   (fail_elem)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic fault = 1'b0;

  logic [DATA_W-1:0] mem [NUM_ARR][DEPTH];

  // RAM model: registered read, write on we; array 1 bit 5 stuck at 1 at address 6.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NUM_ARR; i++) begin
      logic [DATA_W-1:0] rd;
      rd = mem[i][bist_adr];
      if (fault && i == 1 && bist_adr == 3'd6) rd[5] = 1'b1;
      arr_rdata[i*DATA_W +: DATA_W] <= rd;
      if (bist_on && bist_we) mem[i][bist_adr] <= bist_pattern;
    end
  end

  // Scoreboard: expected writes pushed by the stimulus, observed writes by the monitor.
  logic [ADDR_W+DATA_W-1:0] exp_q [$];
  logic [ADDR_W+DATA_W-1:0] obs_q [$];
  int                       obs_cyc [$];

  always @(negedge clk) begin
    if (bist_we) begin
      obs_q.push_back({bist_adr, bist_pattern});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    for (int k = 0; k < limit; k++) begin
      tick();
      n++;
      if (bist_done) break;
    end
  endtask

  task automatic push_march();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] p;
    for (int e = 0; e < 5; e++) begin
      for (int k = 0; k < DEPTH; k++) begin
        a = (e >= 3) ? ADDR_W'(DEPTH - 1 - k) : ADDR_W'(k);
        p = (e == 1 || e == 3) ? ~BG : BG;
        exp_q.push_back({a, p});
      end
    end
  endtask

  task automatic drain_writes(input string tag);
    logic [ADDR_W+DATA_W-1:0] e, o;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check(tag, 64'(o), 64'(e));
    end
    exp_q.delete();
  endtask

  task automatic go_idle();
    bist_mode = 2'b00;
    tick();
    check("idle_done", 64'(bist_done), 64'd0);
    check("idle_on", 64'(bist_on), 64'd0);
  endtask

  int n;
  int first_cyc;

  initial begin
    bist_reset = 1'b1;
    bist_mode  = 2'b00;
    arr_en     = 3'b111;
    tick();
    tick();
    bist_reset = 1'b0;
    tick();
    check("rst_on", 64'(bist_on), 64'd0);
    check("rst_we", 64'(bist_we), 64'd0);
    check("rst_adr", 64'(bist_adr), 64'd0);
    check("rst_pat", 64'(bist_pattern), 64'd0);
    check("rst_done", 64'(bist_done), 64'd0);
    check("rst_err", 64'(err_vec), 64'd0);
    check("rst_berr", 64'(bist_error), 64'd0);
    check("rst_fadr", 64'(fail_adr), 64'd0);
    check("rst_felem", 64'(fail_elem), 64'd0);

    // Clean March C-.
    obs_q.delete(); obs_cyc.delete();
    push_march();
    bist_mode = 2'b01;
    wait_done(200, n);
    check("clean_done_cyc", 64'(n), 64'd82);
    check("clean_err", 64'(err_vec), 64'd0);
    check("clean_berr", 64'(bist_error), 64'd0);
    check("clean_we_count", 64'(obs_q.size()), 64'd40);
    check("done_on", 64'(bist_on), 64'd1);
    check("done_we", 64'(bist_we), 64'd0);
    check("done_adr", 64'(bist_adr), 64'd0);
    drain_writes("clean_wr");
    go_idle();

    // Stuck-at fault on array 1.
    fault = 1'b1;
    bist_mode = 2'b01;
    wait_done(200, n);
    check("fault_done_cyc", 64'(n), 64'd82);
    check("fault_err", 64'(err_vec), 64'b010);
    check("fault_berr", 64'(bist_error), 64'd1);
`ifdef DTAG_MBIST_DIAG_EN
    check("fault_fadr", 64'(fail_adr), 64'd6);
    check("fault_felem", 64'(fail_elem), 64'd1);
`else
    check("fault_fadr", 64'(fail_adr), 64'd0);
    check("fault_felem", 64'(fail_elem), 64'd0);
`endif
    go_idle();
    check("idle_err_kept", 64'(err_vec), 64'b010);

    // Same fault masked by arr_en.
    arr_en = 3'b101;
    bist_mode = 2'b01;
    tick();
    check("restart_err_clr", 64'(err_vec), 64'd0);
    check("restart_fadr_clr", 64'(fail_adr), 64'd0);
    wait_done(200, n);
    check("mask_err", 64'(err_vec), 64'd0);
    go_idle();

    // Fill mode.
    fault = 1'b0;
    arr_en = 3'b111;
    obs_q.delete(); obs_cyc.delete();
    for (int k = 0; k < DEPTH; k++) exp_q.push_back({ADDR_W'(k), BG});
    bist_mode = 2'b10;
    wait_done(200, n);
    check("fill_done_cyc", 64'(n), 64'd10);
    check("fill_we_count", 64'(obs_q.size()), 64'(DEPTH));
    first_cyc = (obs_cyc.size() > 0) ? obs_cyc[0] : 0;
    for (int k = 0; k < obs_cyc.size(); k++)
      check("fill_consecutive", 64'(obs_cyc[k] - first_cyc), 64'(k));
    drain_writes("fill_wr");
    check("fill_err", 64'(err_vec), 64'd0);
    go_idle();

    // Reset in M3, then restart; mode dropped in M2 of the restarted run.
    fault = 1'b1;
    bist_mode = 2'b01;
    for (int k = 0; k < 45; k++) tick();
    check("pre_rst_err", 64'(err_vec), 64'b010);
    bist_reset = 1'b1;
    tick();
    check("mid_rst_on", 64'(bist_on), 64'd0);
    check("mid_rst_we", 64'(bist_we), 64'd0);
    check("mid_rst_err", 64'(err_vec), 64'd0);
    bist_reset = 1'b0;
    n = 0;
    tick();
    n++;
    check("restart_on", 64'(bist_on), 64'd1);
    check("restart_adr", 64'(bist_adr), 64'd0);
    check("restart_we", 64'(bist_we), 64'd1);
    for (int k = 0; k < 200; k++) begin
      if (bist_done) break;
      if (n == 30) bist_mode = 2'b00;
      tick();
      n++;
    end
    check("toggle_done_cyc", 64'(n), 64'd82);
    check("toggle_err", 64'(err_vec), 64'b010);
    tick();
    check("toggle_idle_done", 64'(bist_done), 64'd0);
    check("toggle_idle_on", 64'(bist_on), 64'd0);
    check("toggle_err_kept", 64'(err_vec), 64'b010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
